// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one 5-bit Kogge-Stone adder among NREQ requesters.
// Optional per-requester grant counters when ADDER_ARB_STATS_EN is defined.

module adder (
    input  logic [4:0] a,
    input  logic [4:0] b,
    output logic [4:0] sum,
    output logic       cout
);
    logic [4:0] g0, p0, g1, p1, g2, p2, g3;

    // Prefix levels at distance 1, 2, 4; g3[i] is the group generate of bits [i:0].
    assign g0  = a & b;
    assign p0  = a ^ b;
    assign g1  = g0 | (p0 & {g0[3:0], 1'b0});
    assign p1  = p0 & {p0[3:0], 1'b1};
    assign g2  = g1 | (p1 & {g1[2:0], 2'b00});
    assign p2  = p1 & {p1[2:0], 2'b11};
    assign g3  = g2 | (p2 & {g2[0], 4'b0000});
    assign sum  = p0 ^ {g3[3:0], 1'b0};
    assign cout = g3[4];
endmodule

module adder_share_arb #(
    parameter int NREQ  = 4
`ifdef ADDER_ARB_STATS_EN
  , parameter int CNT_W = 8
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*5-1:0]        req_a,
    input  logic [NREQ*5-1:0]        req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [4:0]               rsp_sum,
    output logic                     rsp_cout,
    output logic                     busy
`ifdef ADDER_ARB_STATS_EN
  , output logic [NREQ*CNT_W-1:0]    grant_cnt
`endif
);
    localparam int ID_W = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [4:0]        a_q, a_d, b_q, b_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [4:0]        rsp_sum_q, rsp_sum_d;
    logic              rsp_cout_q, rsp_cout_d;

    logic [NREQ-1:0][4:0] a_arr, b_arr;
    logic [4:0]        add_sum;
    logic              add_cout;
    logic              arb_en, win_found, accept;
    logic [ID_W-1:0]   win_id, scan_idx;

    assign a_arr = req_a;
    assign b_arr = req_b;

    adder u_adder (.a(a_q), .b(b_q), .sum(add_sum), .cout(add_cout));

    // Arbitration is open in IDLE, and in RESP only when the response leaves this cycle.
    assign arb_en = !rst && ((state_q == IDLE) || (state_q == RESP && rsp_ready));

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_id    = scan_idx;
            end
            scan_idx = (scan_idx == ID_W'(NREQ - 1)) ? '0 : scan_idx + ID_W'(1);
        end
    end

    assign accept    = arb_en && win_found;
    assign req_ready = accept ? (NREQ'(1) << win_id) : '0;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        case (state_q)
            CALC: begin
                rsp_sum_d   = add_sum;
                rsp_cout_d  = add_cout;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: ;
        endcase
        if (accept) begin
            a_d     = a_arr[win_id];
            b_d     = b_arr[win_id];
            id_d    = win_id;
            ptr_d   = (win_id == ID_W'(NREQ - 1)) ? '0 : win_id + ID_W'(1);
            state_d = CALC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign busy      = (state_q != IDLE);

`ifdef ADDER_ARB_STATS_EN
    logic [NREQ-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Saturating counters: a full counter stays at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NREQ; i++) begin
            if (accept && win_id == ID_W'(i) && cnt_q[i] != '1)
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign grant_cnt = cnt_q;
`endif
endmodule

// File: doc/adder_share_arb.md
# adder_share_arb

Round-robin scheduler that shares one 5-bit Kogge-Stone `adder` instance among `NREQ` requesters. It accepts one operand pair at a time through a valid/ready handshake, registers the operands, and drives them into the shared `adder`. It returns the registered sum, carry-out and requester ID on a single response channel with backpressure. The block sits between the requesting units and the single adder instance.

## Interface
- `NREQ`, default 4: number of requesters. Legal values 2..8. `ID_W = $clog2(NREQ)` is a localparam.
- `CNT_W`, default 8: width of each per-requester grant counter. Used only when `ADDER_ARB_STATS_EN` is defined.
- `clk` input 1: the only clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input NREQ: bit i means requester i presents an operand pair.
- `req_ready` output NREQ: one-hot or zero; bit i means requester i's pair is accepted this cycle.
- `req_a` input NREQ*5: operand a, requester i at bits [5i+4:5i].
- `req_b` input NREQ*5: operand b, same packing as `req_a`.
- `rsp_valid` output 1: a response is held on the `rsp_*` outputs.
- `rsp_ready` input 1: the consumer takes the response.
- `rsp_id` output ID_W: index of the requester that owns the response.
- `rsp_sum` output 5: (a+b) mod 32.
- `rsp_cout` output 1: carry-out of a+b.
- `busy` output 1: high whenever the state is not IDLE.
- `grant_cnt` output NREQ*CNT_W: per-requester accepted-request counters. Present only with `ADDER_ARB_STATS_EN`.

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - CALC: operands are registered and the adder is evaluating.
  - RESP: response held until taken.
- Arbitration runs in IDLE, and in RESP in the cycle `rsp_ready`=1.
  - Winner: the first i with `req_valid[i]`=1, scanning ptr, ptr+1, … mod NREQ.
  - `req_ready[winner]`=1 combinationally in that cycle; all other `req_ready` bits are 0.
  - On that edge:
    - `req_a`/`req_b` slice of the winner → operand registers.
    - winner → id register.
    - ptr ← (winner+1) mod NREQ.
    - state → CALC.
- CALC: the `adder` sees the operand registers. On the edge:
  - `adder` sum → `rsp_sum`, cout → `rsp_cout`, id → `rsp_id`.
  - `rsp_valid` ← 1; state → RESP.
- RESP:
  - `rsp_*` outputs are held stable until `rsp_valid` & `rsp_ready`.
  - On handshake with no `req_valid` bits set: `rsp_valid` ← 0, state → IDLE.
  - On handshake with any `req_valid` bit set: accept a new winner in the same cycle and go to CALC; `rsp_valid` ← 0 on that edge.
- `req_ready` is 0 in CALC, and 0 in RESP while `rsp_ready`=0.
- Requesters hold `req_a`/`req_b` stable while valid; they may drop valid before ready.
- The arithmetic is entirely the instantiated `adder`; the block contains no other add logic.

## Timing
- Reset values:
  - state IDLE, ptr 0.
  - `rsp_valid` 0, `rsp_sum` 0, `rsp_cout` 0, `rsp_id` 0, `busy` 0.
  - `req_ready` 0 while `rst`=1.
  - `grant_cnt` all 0.
- Latency: accept edge at T → `rsp_valid`=1 in cycle T+2.
- Throughput: at most one accept per 2 cycles, reached when `rsp_ready` is held at 1.
- Reset mid-operation: any in-flight operation is dropped and no response is produced. The pointer returns to 0.

## Configuration
- `ADDER_ARB_STATS_EN` defined:
  - `grant_cnt[i]` increments on every accept of requester i.
  - Counters saturate at 2^CNT_W−1; they do not wrap.
  - Counters are cleared only by `rst`.
- `ADDER_ARB_STATS_EN` undefined:
  - The `grant_cnt` port and its counters do not exist.
  - All other behaviour is identical.

## Test plan
- Reset then idle: after `rst`, all outputs are 0. With `req_valid`=0 for 10 cycles: `busy`=0 and `rsp_valid`=0 throughout.
- Single request, `rsp_ready`=1: requester 2 sends a=31, b=1, accepted at T. At T+2: `rsp_valid`=1, `rsp_sum`=0, `rsp_cout`=1, `rsp_id`=2.
- Fairness: all 4 requesters valid continuously with `rsp_ready`=1. Accept order is 0,1,2,3,0 with accepts at T, T+2, T+4, …; responses 13+9 → `rsp_sum`=22, `rsp_cout`=0.
- Backpressure: `rsp_ready`=0 for 5 cycles with the response pending. `rsp_*` is stable and `req_ready` is 0 throughout. Raising `rsp_ready` with requester 1 valid gives a handshake plus `req_ready[1]`=1 in the same cycle.
- Reset mid-op: `rst` asserted in CALC. Next cycle: IDLE, `rsp_valid`=0, ptr 0. The next grant with requesters 0 and 3 valid goes to 0.
- Stats, built with `ADDER_ARB_STATS_EN` and `CNT_W`=2: 5 accepts from requester 0 → `grant_cnt[0]`=3, all other counters 0.
